// File: rtl/servant_sleep_ctrl_if.sv
// rtl/servant_sleep_ctrl_if.sv - core/clock-generator signal bundle for the sleep controller
interface servant_sleep_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_sleep_req;
  logic             i_wakeup_req;
  logic             i_ext_irq;
  logic             i_bus_busy;
  logic             o_clk_en;
  logic             o_sleeping;
  logic             o_wake;
  logic             o_abort;
  logic [CNT_W-1:0] o_sleep_cycles;

  modport master (
    output i_sleep_req, i_wakeup_req, i_ext_irq, i_bus_busy,
    input  o_clk_en, o_sleeping, o_wake, o_abort, o_sleep_cycles
  );

  modport slave (
    input  i_sleep_req, i_wakeup_req, i_ext_irq, i_bus_busy,
    output o_clk_en, o_sleeping, o_wake, o_abort, o_sleep_cycles
  );
endinterface

// File: rtl/servant_sleep_ctrl.sv
// rtl/servant_sleep_ctrl.sv - core clock-enable sleep/wake sequencer; sleep counter under SERVANT_SLEEP_CTRL_CNT_EN
module servant_sleep_ctrl #(
  parameter int DRAIN_MAX = 15,
  parameter int WAKE_DLY  = 4,
  parameter int CNT_W     = 32
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  servant_sleep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);
  localparam logic [7:0] WAKE_LAST  = 8'(WAKE_DLY - 1);
  localparam bit         SKIP_WAKE  = (WAKE_DLY == 0);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       irq_meta;
  logic       irq_s;
  logic       wev;
  logic       abort_nxt;
  logic       wake_nxt;
  logic       clk_en_q;
  logic       sleeping_q;
  logic       wake_q;
  logic       abort_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_meta <= 1'b0;
      irq_s    <= 1'b0;
    end else begin
      irq_meta <= bus.i_ext_irq;
      irq_s    <= irq_meta;
    end
  end

  assign wev = bus.i_wakeup_req | irq_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort_nxt = 1'b0;
    wake_nxt  = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.i_sleep_req) begin
          if (wev) begin
            abort_nxt = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = 8'd0;
          end
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt + 8'd1;
        // A wake event beats both the idle bus and the timeout.
        if (wev) begin
          state_nxt = ST_RUN;
          abort_nxt = 1'b1;
        end else if (!bus.i_bus_busy) begin
          state_nxt = ST_SLEEP;
          cnt_nxt   = 8'd0;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = ST_RUN;
          abort_nxt = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (wev) begin
          if (SKIP_WAKE) begin
            state_nxt = ST_RUN;
            wake_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAKE;
            cnt_nxt   = 8'd0;
          end
        end
      end
      ST_WAKE: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == WAKE_LAST) begin
          state_nxt = ST_RUN;
          wake_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_RUN;
      cnt        <= 8'd0;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
      wake_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clk_en_q   <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      sleeping_q <= (state_nxt == ST_SLEEP) || (state_nxt == ST_WAKE);
      wake_q     <= wake_nxt;
      abort_q    <= abort_nxt;
    end
  end

  assign bus.o_clk_en   = clk_en_q;
  assign bus.o_sleeping = sleeping_q;
  assign bus.o_wake     = wake_q;
  assign bus.o_abort    = abort_q;

`ifdef SERVANT_SLEEP_CTRL_CNT_EN
  logic [CNT_W-1:0] slp_cnt;
  logic [CNT_W-1:0] slp_inc;
  logic [CNT_W-1:0] sleep_cycles_q;

  assign slp_inc = (&slp_cnt) ? slp_cnt : slp_cnt + CNT_W'(1);

  // The exit edge itself counts as a sleep cycle, so the latched value is the incremented count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slp_cnt        <= '0;
      sleep_cycles_q <= '0;
    end else if (state == ST_SLEEP) begin
      if (state_nxt != ST_SLEEP) begin
        sleep_cycles_q <= slp_inc;
        slp_cnt        <= '0;
      end else begin
        slp_cnt <= slp_inc;
      end
    end else begin
      slp_cnt <= '0;
    end
  end

  assign bus.o_sleep_cycles = sleep_cycles_q;
`else
  assign bus.o_sleep_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// tb/tb_servant_sleep_ctrl.sv - self-checking bench for servant_sleep_ctrl (WAKE_DLY 4 and 0 side by side)
module tb_servant_sleep_ctrl;
  localparam int DRAIN_MAX = 15;
  localparam int CNT_W     = 32;
`ifdef SERVANT_SLEEP_CTRL_CNT_EN
  localparam int SC_BASIC = 20;
`else
  localparam int SC_BASIC = 0;
`endif

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic sleep_req  = 1'b0;
  logic wakeup_req = 1'b0;
  logic ext_irq    = 1'b0;
  logic bus_busy   = 1'b0;
  int   total      = 0;
  int   bad        = 0;

  always #5 clk = ~clk;

  servant_sleep_ctrl_if #(.CNT_W(CNT_W)) if4 ();
  servant_sleep_ctrl_if #(.CNT_W(CNT_W)) if0 ();

  assign if4.i_sleep_req  = sleep_req;
  assign if4.i_wakeup_req = wakeup_req;
  assign if4.i_ext_irq    = ext_irq;
  assign if4.i_bus_busy   = bus_busy;
  assign if0.i_sleep_req  = sleep_req;
  assign if0.i_wakeup_req = wakeup_req;
  assign if0.i_ext_irq    = ext_irq;
  assign if0.i_bus_busy   = bus_busy;

  servant_sleep_ctrl #(.DRAIN_MAX(DRAIN_MAX), .WAKE_DLY(4), .CNT_W(CNT_W)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if4)
  );
  servant_sleep_ctrl #(.DRAIN_MAX(DRAIN_MAX), .WAKE_DLY(0), .CNT_W(CNT_W)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0)
  );

  // Reference: timestamps of phase entry against an edge counter, one slot per instance.
  typedef enum {M_RUN, M_DRAIN, M_SLEEP, M_WAKE} mmode_t;
  mmode_t      m_mode  [2];
  int          m_t0    [2];
  logic [31:0] m_cyc   [2];
  logic        m_abort [2];
  logic        m_wake  [2];
  int          e_now = 0;
  logic        irq_h1 = 1'b0;
  logic        irq_h2 = 1'b0;

  function automatic int wdly(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i]  = M_RUN;
      m_t0[i]    = 0;
      m_cyc[i]   = 32'd0;
      m_abort[i] = 1'b0;
      m_wake[i]  = 1'b0;
    end
    irq_h1 = 1'b0;
    irq_h2 = 1'b0;
  endtask

  task automatic model_edge();
    logic wev;
    e_now++;
    wev = wakeup_req | irq_h2;
    for (int i = 0; i < 2; i++) begin
      m_abort[i] = 1'b0;
      m_wake[i]  = 1'b0;
      case (m_mode[i])
        M_RUN: begin
          if (sleep_req) begin
            if (wev) m_abort[i] = 1'b1;
            else begin
              m_mode[i] = M_DRAIN;
              m_t0[i]   = e_now;
            end
          end
        end
        M_DRAIN: begin
          if (wev) begin
            m_mode[i]  = M_RUN;
            m_abort[i] = 1'b1;
          end else if (!bus_busy) begin
            m_mode[i] = M_SLEEP;
            m_t0[i]   = e_now;
          end else if (e_now - m_t0[i] == DRAIN_MAX) begin
            m_mode[i]  = M_RUN;
            m_abort[i] = 1'b1;
          end
        end
        M_SLEEP: begin
          if (wev) begin
            m_cyc[i] = 32'(e_now - m_t0[i]);
            m_t0[i]  = e_now;
            if (wdly(i) == 0) begin
              m_mode[i] = M_RUN;
              m_wake[i] = 1'b1;
            end else begin
              m_mode[i] = M_WAKE;
            end
          end
        end
        M_WAKE: begin
          if (e_now - m_t0[i] == wdly(i)) begin
            m_mode[i] = M_RUN;
            m_wake[i] = 1'b1;
          end
        end
        default: m_mode[i] = M_RUN;
      endcase
    end
    irq_h2 = irq_h1;
    irq_h1 = ext_irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int i, input logic ce, input logic sl, input logic wk,
                         input logic ab, input logic [CNT_W-1:0] sc);
    logic [31:0] exp_sc;
`ifdef SERVANT_SLEEP_CTRL_CNT_EN
    exp_sc = m_cyc[i];
`else
    exp_sc = 32'd0;
`endif
    chk($sformatf("d%0d.clk_en t=%0t", wdly(i), $time), 32'(ce),
        32'((m_mode[i] == M_RUN) || (m_mode[i] == M_DRAIN)));
    chk($sformatf("d%0d.sleeping t=%0t", wdly(i), $time), 32'(sl),
        32'((m_mode[i] == M_SLEEP) || (m_mode[i] == M_WAKE)));
    chk($sformatf("d%0d.wake t=%0t", wdly(i), $time), 32'(wk), 32'(m_wake[i]));
    chk($sformatf("d%0d.abort t=%0t", wdly(i), $time), 32'(ab), 32'(m_abort[i]));
    chk($sformatf("d%0d.sleep_cycles t=%0t", wdly(i), $time), 32'(sc), exp_sc);
  endtask

  task automatic check_all();
    chk_dut(0, if4.o_clk_en, if4.o_sleeping, if4.o_wake, if4.o_abort, if4.o_sleep_cycles);
    chk_dut(1, if0.o_clk_en, if0.o_sleeping, if0.o_wake, if0.o_abort, if0.o_sleep_cycles);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k4;
    int k0;
    int wakes4;
    int wakes0;
    int ce_low;
    int ab_seen;

    // Reset held for three cycles
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset.clk_en", 32'(if4.o_clk_en), 32'd1);
    chk("reset.sleeping", 32'(if4.o_sleeping), 32'd0);
    chk("reset.pulses", 32'({if4.o_wake, if4.o_abort, if0.o_wake, if0.o_abort}), 32'd0);
    chk("reset.sleep_cycles", 32'(if4.o_sleep_cycles), 32'd0);
    tick();

    // Basic sleep and timer wake: 20 cycles in SLEEP
    bus_busy  = 1'b0;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    chk("basic.drain_clk_en", 32'(if4.o_clk_en), 32'd1);
    tick();
    chk("basic.gated", 32'(if4.o_clk_en), 32'd0);
    repeat (19) tick();
    wakeup_req = 1'b1;
    k4 = 0; k0 = 0; wakes4 = 0; wakes0 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      wakeup_req = 1'b0;
      if (if4.o_wake) wakes4++;
      if (if0.o_wake) wakes0++;
      if (k4 == 0 && if4.o_clk_en) k4 = k;
      if (k0 == 0 && if0.o_clk_en) k0 = k;
    end
    chk("basic.resume_edges_d4", 32'(k4), 32'd5);
    chk("basic.resume_edges_d0", 32'(k0), 32'd1);
    chk("basic.wake_count_d4", 32'(wakes4), 32'd1);
    chk("basic.wake_count_d0", 32'(wakes0), 32'd1);
    chk("basic.sleep_cycles_d4", 32'(if4.o_sleep_cycles), 32'(SC_BASIC));
    chk("basic.sleep_cycles_d0", 32'(if0.o_sleep_cycles), 32'(SC_BASIC));

    // Drain timeout with the bus permanently busy
    bus_busy  = 1'b1;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    k4 = 0; ce_low = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!if4.o_clk_en) ce_low = 1;
      if (if4.o_abort) begin
        k4 = k;
        break;
      end
    end
    chk("drain.abort_edge", 32'(k4), 32'(DRAIN_MAX));
    chk("drain.clk_en_held", 32'(ce_low), 32'd0);
    tick();

    // Bus goes idle six cycles into DRAIN
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    ab_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if4.o_abort) ab_seen = 1;
    end
    bus_busy = 1'b0;
    tick();
    chk("idle.gated", 32'(if4.o_clk_en), 32'd0);
    chk("idle.sleeping", 32'(if4.o_sleeping), 32'd1);
    chk("idle.no_abort", 32'(ab_seen | int'(if4.o_abort)), 32'd0);
    wakeup_req = 1'b1;
    tick();
    wakeup_req = 1'b0;
    repeat (6) tick();

    // External interrupt raised mid-cycle while sleeping
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    ext_irq = 1'b1;
    tick();
    tick();
    chk("irq.edge2_gated_d0", 32'(if0.o_clk_en), 32'd0);
    tick();
    chk("irq.edge3_clk_en_d0", 32'(if0.o_clk_en), 32'd1);
    chk("irq.edge3_wake_d0", 32'(if0.o_wake), 32'd1);
    repeat (6) tick();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    chk("irq.held_abort_d4", 32'(if4.o_abort), 32'd1);
    chk("irq.held_abort_d0", 32'(if0.o_abort), 32'd1);
    ext_irq = 1'b0;
    repeat (3) tick();

    // Sleep and wake requested in the same cycle
    sleep_req  = 1'b1;
    wakeup_req = 1'b1;
    tick();
    sleep_req  = 1'b0;
    wakeup_req = 1'b0;
    chk("simul.abort", 32'(if4.o_abort), 32'd1);
    chk("simul.clk_en", 32'(if4.o_clk_en), 32'd1);
    tick();

    // Asynchronous reset during SLEEP
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    repeat (3) tick();
    chk("areset.pre_sleeping", 32'(if4.o_sleeping), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.clk_en_d4", 32'(if4.o_clk_en), 32'd1);
    chk("areset.clk_en_d0", 32'(if0.o_clk_en), 32'd1);
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the reference
    for (int n = 0; n < 1500; n++) begin
      sleep_req  = ($urandom_range(0, 5) == 0);
      wakeup_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) bus_busy = ~bus_busy;
      if ($urandom_range(0, 60) == 0) ext_irq = ~ext_irq;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
